// File: rtl/hack_pkg.sv
// Shared types and instruction-field constants for the multicycle Hack CPU.
package hack_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MRD   = 2'd1,
    S_EXEC  = 2'd2,
    S_MWR   = 2'd3
  } state_t;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  localparam int BIT_A   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

endpackage

// File: rtl/alu.sv
// Hack ALU: comp = {zx, nx, zy, ny, f, no}; zr/ng flags describe the result.
module alu #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  logic [5:0]        i_comp,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zr,
  output logic              o_ng
);

  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_f;

  always_comb begin
    w_x = i_comp[5] ? '0 : i_x;
    w_x = i_comp[4] ? ~w_x : w_x;
    w_y = i_comp[3] ? '0 : i_y;
    w_y = i_comp[2] ? ~w_y : w_y;
    w_f = i_comp[1] ? (w_x + w_y) : (w_x & w_y);
    o_out = i_comp[0] ? ~w_f : w_f;
  end

  assign o_zr = (o_out == '0);
  assign o_ng = o_out[DATA_W-1];

endmodule

// File: rtl/hack_jump_unit.sv
// Jump condition evaluation from the ALU flags; A-instructions never jump.
module hack_jump_unit
  import hack_pkg::*;
(
  input  logic [2:0] i_jump,
  input  logic       i_zr,
  input  logic       i_ng,
  input  logic       i_is_c,
  output logic       o_taken
);

  logic w_gt;
  logic w_cond;

  assign w_gt = ~i_zr & ~i_ng;

  always_comb begin
    w_cond = 1'b0;
    case (i_jump)
      JNULL: w_cond = 1'b0;
      JGT:   w_cond = w_gt;
      JEQ:   w_cond = i_zr;
      JGE:   w_cond = i_zr | w_gt;
      JLT:   w_cond = i_ng;
      JNE:   w_cond = ~i_zr;
      JLE:   w_cond = i_zr | i_ng;
      JMP:   w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_taken = i_is_c & w_cond;

endmodule

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU with req/ack instruction and data memory ports.
// Define CPU_PERF_EN to add the cycle_cnt / retired_cnt performance counters.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire
`ifdef CPU_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       retired_cnt
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_next_pc;
  logic [ADDR_W-1:0] r_daddr;
  logic              r_ireq;
  logic              r_dreq;
  logic              r_we;
  logic              r_retire;

  logic              w_is_c;
  logic              w_wr_m;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_alu;
  logic              w_zr;
  logic              w_ng;
  logic              w_taken;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_is_c    = r_ir[DATA_W-1];
  assign w_wr_m    = w_is_c & r_ir[DEST_M];
  assign w_y       = r_ir[BIT_A] ? r_m : r_a;
  assign w_imm     = {1'b0, r_ir[DATA_W-2:0]};
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  // r_a is still the pre-instruction A here, so jumps target the old A.
  assign w_next_pc = w_taken ? r_a[ADDR_W-1:0] : w_pc_inc;

  alu #(.DATA_W(DATA_W)) u_alu (
    .i_x    (r_d),
    .i_y    (w_y),
    .i_comp (r_ir[COMP_HI:COMP_LO]),
    .o_out  (w_alu),
    .o_zr   (w_zr),
    .o_ng   (w_ng)
  );

  hack_jump_unit u_jump (
    .i_jump  (r_ir[JUMP_HI:JUMP_LO]),
    .i_zr    (w_zr),
    .i_ng    (w_ng),
    .i_is_c  (w_is_c),
    .o_taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_a       <= '0;
      r_d       <= '0;
      r_m       <= '0;
      r_wdata   <= '0;
      r_pc      <= RESET_PC;
      r_next_pc <= RESET_PC;
      r_daddr   <= '0;
      r_ireq    <= 1'b0;
      r_dreq    <= 1'b0;
      r_we      <= 1'b0;
      r_retire  <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here with req low.
          if (!r_ireq) begin
            r_ireq <= 1'b1;
          end else if (imem_ack) begin
            r_ir   <= imem_rdata;
            r_ireq <= 1'b0;
            if (imem_rdata[DATA_W-1] & imem_rdata[BIT_A]) begin
              r_dreq  <= 1'b1;
              r_we    <= 1'b0;
              r_daddr <= r_a[ADDR_W-1:0];
              r_state <= S_MRD;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_MRD: begin
          if (dmem_ack) begin
            r_m     <= dmem_rdata;
            r_dreq  <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!w_is_c) begin
            r_a <= w_imm;
          end else if (r_ir[DEST_A]) begin
            r_a <= w_alu;
          end
          if (w_is_c & r_ir[DEST_D]) begin
            r_d <= w_alu;
          end
          if (w_wr_m) begin
            r_dreq    <= 1'b1;
            r_we      <= 1'b1;
            r_daddr   <= r_a[ADDR_W-1:0];
            r_wdata   <= w_alu;
            r_next_pc <= w_next_pc;
            r_state   <= S_MWR;
          end else begin
            r_pc     <= w_next_pc;
            r_retire <= 1'b1;
            r_ireq   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_MWR: begin
          if (dmem_ack) begin
            r_dreq   <= 1'b0;
            r_we     <= 1'b0;
            r_pc     <= r_next_pc;
            r_retire <= 1'b1;
            r_ireq   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req   = r_ireq;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dreq;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_daddr;
  assign dmem_wdata = r_wdata;
  assign pc         = r_pc;
  assign retire     = r_retire;

`ifdef CPU_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (r_retire) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: retire PCs and data-memory traffic are queued and checked on output.
module tb_hack_cpu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic [14:0] pc;
  logic        retire;
`ifdef CPU_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;
`endif

  always #5 clk = ~clk;

  hack_cpu_mc dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .retire     (retire)
`ifdef CPU_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  logic [15:0] imem [int];
  logic [15:0] dmem [int];
  logic [31:0] exp_pc [$];
  logic [31:0] exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] d_snap;

  int n_vec = 0;
  int n_err = 0;
  int iwait = 0;
  int dwait = 0;
  int icnt = 0;
  int dcnt = 0;
  int d_len = 0;
  int n_ret = 0;
  int ret_at_dreq = -1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (imem_req) begin
      if (icnt >= iwait) begin
        imem_ack   = 1'b1;
        imem_rdata = imem.exists(int'(imem_addr)) ? imem[int'(imem_addr)] : 16'h0000;
        icnt       = 0;
      end else begin
        icnt++;
      end
    end else begin
      icnt = 0;
    end
  end

  always @(negedge clk) begin
    dmem_ack = 1'b0;
    if (dmem_req && !reset) begin
      if (ret_at_dreq < 0) ret_at_dreq = n_ret;
      if (dcnt == 0) d_snap = {dmem_we, dmem_addr, dmem_wdata};
      else check_val("dmem_hold", {dmem_we, dmem_addr, dmem_wdata}, d_snap);
      if (dcnt >= dwait) begin
        dmem_ack = 1'b1;
        d_len    = dcnt + 1;
        dcnt     = 0;
        if (dmem_we) begin
          dmem[int'(dmem_addr)] = dmem_wdata;
          check_val("wr_pending", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) check_val("dmem_wr", {1'b0, dmem_addr, dmem_wdata}, exp_wr.pop_front());
        end else begin
          dmem_rdata = dmem.exists(int'(dmem_addr)) ? dmem[int'(dmem_addr)] : 16'h0000;
          check_val("rd_pending", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) check_val("dmem_rd_addr", 32'(dmem_addr), exp_rd.pop_front());
        end
      end else begin
        dcnt++;
      end
    end else begin
      dcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (retire && !reset) begin
      n_ret++;
      if (exp_pc.size() > 0) check_val("retire_pc", 32'(pc), exp_pc.pop_front());
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_pc.delete();
    exp_wr.delete();
    exp_rd.delete();
    imem.delete();
    dmem.delete();
    n_ret       = 0;
    ret_at_dreq = -1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_pc.size() + exp_wr.size() + exp_rd.size()) > 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_val("drain_left", 32'(exp_pc.size() + exp_wr.size() + exp_rd.size()), 32'd0);
  endtask

  initial begin
    int c;
    // reset state
    apply_reset();
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_imem_req", 32'(imem_req), 32'd0);
    check_val("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_val("rst_dmem_we", 32'(dmem_we), 32'd0);
    check_val("rst_retire", 32'(retire), 32'd0);
    check_val("rst_daddr_wdata", {1'b0, dmem_addr, dmem_wdata}, 32'd0);

    // @5 D=A @7 0;JMP, then @20 M=D at 7
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0007; imem[3] = 16'hEA87;
    imem[7] = 16'h0014; imem[8] = 16'hE308;
    exp_pc = '{32'd1, 32'd2, 32'd3, 32'd7, 32'd8, 32'd9};
    exp_wr.push_back({1'b0, 15'd20, 16'd5});
    iwait = 0; dwait = 0;
    release_reset();
    drain(200);
    check_val("first_dreq_after_n_retires", 32'(ret_at_dreq), 32'd5);

    // @100 M=1 with three wait states
    apply_reset();
    imem[0] = 16'h0064; imem[1] = 16'hEFC8;
    exp_pc = '{32'd1, 32'd2};
    exp_wr.push_back({1'b0, 15'd100, 16'd1});
    dwait = 3;
    release_reset();
    drain(200);
    check_val("mwr_req_cycles", 32'(d_len), 32'd4);

    // AM=M+1;JMP uses old A for both the write and the jump
    apply_reset();
    dmem[100] = 16'd9;
    imem[0] = 16'h0064; imem[1] = 16'hFDEF;
    imem[100] = 16'hEC10; imem[101] = 16'h0032; imem[102] = 16'hE308;
    exp_pc = '{32'd1, 32'd100, 32'd101, 32'd102, 32'd103};
    exp_rd.push_back(32'd100);
    exp_wr.push_back({1'b0, 15'd100, 16'd10});
    exp_wr.push_back({1'b0, 15'd50, 16'd10});
    iwait = 2; dwait = 0;
    release_reset();
    drain(300);

    // conditional jumps on D=-1 and D=0
    apply_reset();
    imem[0]  = 16'hEE90; imem[1]  = 16'h000A; imem[2]  = 16'hE304;
    imem[10] = 16'h0014; imem[11] = 16'hE303;
    imem[12] = 16'h001E; imem[13] = 16'hE305;
    imem[30] = 16'hEA90; imem[31] = 16'h0028; imem[32] = 16'hE302;
    exp_pc = '{32'd1, 32'd2, 32'd10, 32'd11, 32'd12, 32'd13, 32'd30, 32'd31, 32'd32, 32'd40};
    iwait = 1;
    release_reset();
    drain(300);

    // reset while D=M is waiting for its read
    apply_reset();
    imem[0] = 16'hEE90; imem[1] = 16'h0064; imem[2] = 16'hFC10;
    exp_pc = '{32'd1, 32'd2};
    iwait = 0; dwait = 6;
    release_reset();
    drain(100);
    c = 0;
    while (!dmem_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_val("mrd_reached", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("mrd_rst_dmem_req", 32'(dmem_req), 32'd0);
    check_val("mrd_rst_pc", 32'(pc), 32'd0);
    check_val("mrd_rst_retire", 32'(retire), 32'd0);
    apply_reset();
    imem[0] = 16'hE308;
    exp_pc = '{32'd1};
    exp_wr.push_back({1'b0, 15'd0, 16'd0});
    dwait = 0;
    release_reset();
    drain(100);

    // pc wrap from the top of the address space
    apply_reset();
    imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[32767] = 16'h0005;
    exp_pc = '{32'd1, 32'd32767, 32'd0};
    release_reset();
    drain(100);

`ifdef CPU_PERF_EN
    apply_reset();
    release_reset();
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("cycle_cnt", cycle_cnt, 32'd10);
    check_val("retired_cnt", retired_cnt, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
